tla_com_ctrl: RTL and testbench
===============================

TLA_COM_CTRL -- requirements
Module: tla_com_ctrl

Interface
REQ-001 Parameter TOP0_0, default 3: window-select (wdis) width; channel-enable width is 2**TOP0_0.
REQ-002 Parameter LDD0_0, default 32: pulse-length and gap-length counter width.
REQ-003 Port Ga_clk200  in  1: sole clock; all logic is on its rising edge.
REQ-004 Port Gc_rst  in  1: reset, asynchronous, active-high.
REQ-005 Port Ga_com_open  in  1: single-cycle start request, already synchronous to Ga_clk200.
REQ-006 Port Ga_com_close  in  1: single-cycle abort/stop request, already synchronous to Ga_clk200.
REQ-007 Port Ga_cap_mode  in  1: 0 = single-shot, 1 = repeat; sampled with open.
REQ-008 Port Ga_com_wdis  in  TOP0_0: window/channel select; sampled with open.
REQ-009 Port Ga_com_plus  in  LDD0_0: pulse high length in cycles; sampled with open.
REQ-010 Port Ga_cap_plus  in  LDD0_0: repeat-mode gap length in cycles; sampled with open.
REQ-011 Port Ga_pulse  out  1: generated pulse.
REQ-012 Port Ga_chan_en  out  2**TOP0_0: one-hot of latched wdis, asserted only while Ga_pulse=1.
REQ-013 Port Ga_wdis  out  TOP0_0: latched wdis while busy, 0 when idle (status returned to control domain).
REQ-014 Port Ga_busy  out  1: high in any state other than IDLE.
REQ-015 Port Ga_err  out  1: single-cycle flag on a rejected open.
REQ-016 Port Ga_cnt  out  16: completed-pulse count since the last accepted open, saturating at 0xFFFF.

Function
REQ-017 FSM states SHALL be IDLE, HIGH, GAP.
REQ-018 IDLE + open + !close + plus!=0 SHALL latch mode/wdis/plus/gap, clear Ga_cnt, and enter HIGH next cycle.
REQ-019 Ga_pulse SHALL go high the cycle after open is sampled and stay high exactly latched-plus cycles.
REQ-020 At the end of HIGH, Ga_cnt SHALL increment (saturating); single-shot -> IDLE, repeat -> GAP.
REQ-021 GAP SHALL last latched-gap cycles with Ga_pulse=0, then -> HIGH; gap=0 SHALL be treated as 1.
REQ-022 close in HIGH or GAP SHALL force IDLE on the next edge; Ga_pulse and Ga_chan_en low that same cycle; Ga_cnt holds.
REQ-023 open while not IDLE SHALL be ignored (no error, no relatch).
REQ-024 open with plus=0 in IDLE SHALL be rejected: stay IDLE, pulse Ga_err for one cycle.
REQ-025 Simultaneous open and close in IDLE: close wins, open ignored, no Ga_err.
REQ-026 Input changes to wdis/plus/gap/mode after acceptance SHALL NOT affect the running sequence.
REQ-027 Counters SHALL be LDD0_0 bits, down-counting, no wrap; plus=2**LDD0_0-1 SHALL be honoured exactly.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 Gc_rst high SHALL asynchronously force IDLE and all outputs to 0, including mid-pulse.
REQ-030 After Gc_rst deasserts, an open in the first clock edge SHALL be accepted normally.

Structure
REQ-031 FSM state encoding and TOP0_0/LDD0_0 defaults SHALL live in the shared Tla package.
REQ-032 One sub-module, tla_onehot_dec (wdis -> one-hot), is natural; counter and FSM stay inline.

Verification
REQ-033 Single-shot: mode=0, wdis=5, plus=4, open at cycle 10 -> Ga_pulse high cycles 11-14, Ga_chan_en=0x20 during them, Ga_cnt=1, Ga_busy low from cycle 15.
REQ-034 Repeat: mode=1, plus=3, gap=2, close at cycle 20 after open at cycle 0 -> high 1-3, 6-8, 11-13, 16-18; idle from 21; Ga_cnt=4.
REQ-035 Rejection: plus=0 open -> Ga_err one cycle, Ga_busy stays 0; open+close together in IDLE -> nothing, Ga_err 0.
REQ-036 Re-open ignore: second open with wdis=2 during running pulse -> Ga_wdis unchanged, timing unchanged.
REQ-037 Reset mid-pulse: Gc_rst asserted mid-HIGH -> all outputs 0 immediately (asynchronously); open after release runs normally.
REQ-038 Gap=0 repeat with plus=1 -> pulse high every second cycle; Ga_cnt saturates at 0xFFFF after 65535 pulses.

Source files
------------

// File: rtl/tla_com_ctrl_pkg.sv
// Shared definitions for the TLA pulse controller: default widths, FSM encoding
// and the saturating completed-pulse counter step.
package tla_com_ctrl_pkg;

    localparam int TLA_TOP0_0 = 3;
    localparam int TLA_LDD0_0 = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } tla_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tla_com_ctrl_onehot_dec.sv
// Binary window select to one-hot channel enable.
module tla_onehot_dec #(
    parameter int W = 3
) (
    input  logic [W-1:0]        sel,
    output logic [(1<<W)-1:0]   onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/tla_com_ctrl.sv
// Pulse/gap sequencer: an accepted open drives a single or repeating pulse on
// the selected channel until it finishes or is closed.
//
// state   | meaning
// IDLE    | waiting for an open with nonzero pulse length
// HIGH    | pulse asserted, timer counts latched pulse length
// GAP     | repeat mode only, pulse low, timer counts latched gap length
module tla_com_ctrl
    import tla_com_ctrl_pkg::*;
#(
    parameter int TOP0_0 = TLA_TOP0_0,
    parameter int LDD0_0 = TLA_LDD0_0
) (
    input  logic                     Ga_clk200,
    input  logic                     Gc_rst,
    input  logic                     Ga_com_open,
    input  logic                     Ga_com_close,
    input  logic                     Ga_cap_mode,
    input  logic [TOP0_0-1:0]        Ga_com_wdis,
    input  logic [LDD0_0-1:0]        Ga_com_plus,
    input  logic [LDD0_0-1:0]        Ga_cap_plus,
    output logic                     Ga_pulse,
    output logic [(1<<TOP0_0)-1:0]   Ga_chan_en,
    output logic [TOP0_0-1:0]        Ga_wdis,
    output logic                     Ga_busy,
    output logic                     Ga_err,
    output logic [15:0]              Ga_cnt
);

    localparam logic [LDD0_0-1:0] TMR_ONE = {{(LDD0_0-1){1'b0}}, 1'b1};

    tla_state_e          state_q, state_d;
    logic                mode_q, mode_d;
    logic [TOP0_0-1:0]   wdis_q, wdis_d;
    logic [LDD0_0-1:0]   plus_q, plus_d;
    logic [LDD0_0-1:0]   gap_q, gap_d;
    logic [LDD0_0-1:0]   tmr_q, tmr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                err_d;
    logic [(1<<TOP0_0)-1:0] chan_d;

    tla_onehot_dec #(.W(TOP0_0)) u_dec (
        .sel    (wdis_d),
        .onehot (chan_d)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        wdis_d  = wdis_q;
        plus_d  = plus_q;
        gap_d   = gap_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (Ga_com_open && !Ga_com_close) begin
                    if (Ga_com_plus == '0) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = Ga_cap_mode;
                        wdis_d  = Ga_com_wdis;
                        plus_d  = Ga_com_plus;
                        gap_d   = (Ga_cap_plus == '0) ? TMR_ONE : Ga_cap_plus;
                        tmr_d   = Ga_com_plus;
                        cnt_d   = '0;
                        state_d = ST_HIGH;
                    end
                end
            end
            ST_HIGH: begin
                // close takes priority over a pulse completing on the same edge
                if (Ga_com_close) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == TMR_ONE) begin
                    cnt_d = sat_inc16(cnt_q);
                    if (mode_q) begin
                        state_d = ST_GAP;
                        tmr_d   = gap_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            ST_GAP: begin
                if (Ga_com_close) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == TMR_ONE) begin
                    state_d = ST_HIGH;
                    tmr_d   = plus_q;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state.
    always_ff @(posedge Ga_clk200 or posedge Gc_rst) begin
        if (Gc_rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            wdis_q     <= '0;
            plus_q     <= '0;
            gap_q      <= '0;
            tmr_q      <= '0;
            cnt_q      <= '0;
            Ga_pulse   <= 1'b0;
            Ga_chan_en <= '0;
            Ga_wdis    <= '0;
            Ga_busy    <= 1'b0;
            Ga_err     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wdis_q     <= wdis_d;
            plus_q     <= plus_d;
            gap_q      <= gap_d;
            tmr_q      <= tmr_d;
            cnt_q      <= cnt_d;
            Ga_pulse   <= (state_d == ST_HIGH);
            Ga_chan_en <= (state_d == ST_HIGH) ? chan_d : '0;
            Ga_wdis    <= (state_d != ST_IDLE) ? wdis_d : '0;
            Ga_busy    <= (state_d != ST_IDLE);
            Ga_err     <= err_d;
        end
    end

    assign Ga_cnt = cnt_q;

endmodule

// File: tb/tb_tla_com_ctrl.sv
// Bench for tla_com_ctrl: directed vector table, multi-cycle sequences and a
// randomized run checked against a schedule-based reference model.
module tb_tla_com_ctrl;

    localparam longint BIG = 64'h3FFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        open_i = 1'b0, close_i = 1'b0, mode_i = 1'b0;
    logic [2:0]  wdis_i = '0;
    logic [31:0] plus_i = '0, gap_i = '0;
    logic        pulse, busy, err;
    logic [7:0]  chan;
    logic [2:0]  wdis_o;
    logic [15:0] cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tla_com_ctrl #(.TOP0_0(3), .LDD0_0(32)) dut (
        .Ga_clk200    (clk),
        .Gc_rst       (rst),
        .Ga_com_open  (open_i),
        .Ga_com_close (close_i),
        .Ga_cap_mode  (mode_i),
        .Ga_com_wdis  (wdis_i),
        .Ga_com_plus  (plus_i),
        .Ga_cap_plus  (gap_i),
        .Ga_pulse     (pulse),
        .Ga_chan_en   (chan),
        .Ga_wdis      (wdis_o),
        .Ga_busy      (busy),
        .Ga_err       (err),
        .Ga_cnt       (cnt)
    );

    // Reference model: an accepted run is a schedule starting at cycle m_s with
    // period m_per; pulse k completes at edge m_s + k*m_per + m_plus.
    longint cyc = 0;
    bit     m_run = 0;
    bit     m_err = 0;
    bit     m_mode = 0;
    int     m_wdis = 0;
    longint m_s = 0, m_close = BIG, m_plus = 1, m_per = 1;

    function automatic bit m_busy(input longint c);
        if (!m_run || c < m_s || c >= m_close) return 1'b0;
        if (!m_mode && c >= m_s + m_plus) return 1'b0;
        return 1'b1;
    endfunction

    function automatic longint m_count(input longint c);
        longint lim, n;
        if (!m_run) return 0;
        lim = (c < m_close - 1) ? c : m_close - 1;
        if (lim < m_s + m_plus) return 0;
        n = m_mode ? (lim - m_s - m_plus) / m_per + 1 : 1;
        return (n > 65535) ? 65535 : n;
    endfunction

    task automatic model_edge();
        m_err = 1'b0;
        if (m_busy(cyc - 1)) begin
            if (close_i) m_close = cyc;
        end else if (open_i && !close_i) begin
            if (plus_i == 0) begin
                m_err = 1'b1;
            end else begin
                m_run   = 1'b1;
                m_s     = cyc;
                m_close = BIG;
                m_mode  = mode_i;
                m_wdis  = int'(wdis_i);
                m_plus  = longint'(plus_i);
                m_per   = longint'(plus_i) + ((gap_i == 0) ? 1 : longint'(gap_i));
            end
        end
    endtask

    task automatic tick(input bit o, input bit c, input bit md,
                        input logic [2:0] w, input logic [31:0] p, input logic [31:0] g);
        open_i  = o;
        close_i = c;
        mode_i  = md;
        wdis_i  = w;
        plus_i  = p;
        gap_i   = g;
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
    endtask

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [29:0] outs();
        return {pulse, chan, wdis_o, busy, err, cnt};
    endfunction

    task automatic check_model(input string nm);
        bit b, p;
        logic [29:0] e;
        b = m_busy(cyc);
        p = 1'b0;
        if (b) p = (((cyc - m_s) % m_per) < m_plus);
        e = {p, p ? (8'd1 << m_wdis) : 8'd0, b ? 3'(m_wdis) : 3'd0, b, m_err,
             16'(m_count(cyc))};
        check(nm, longint'(outs()), longint'(e));
    endtask

    task automatic do_reset();
        open_i = 0; close_i = 0; mode_i = 0; wdis_i = '0; plus_i = '0; gap_i = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_run = 0; m_err = 0; cyc = 0; m_close = BIG;
    endtask

    typedef struct {
        bit          o, c, md;
        logic [2:0]  w;
        logic [31:0] p, g;
        bit          ep;
        logic [7:0]  ech;
        logic [2:0]  ew;
        bit          eb, ee;
        logic [15:0] ec;
    } vec_t;

    function automatic vec_t mk(input bit o, input bit c, input bit md, input int w,
                                input int p, input int g, input bit ep, input int ech,
                                input int ew, input bit eb, input bit ee, input int ec);
        vec_t v;
        v.o = o; v.c = c; v.md = md; v.w = 3'(w); v.p = 32'(p); v.g = 32'(g);
        v.ep = ep; v.ech = 8'(ech); v.ew = 3'(ew); v.eb = eb; v.ee = ee; v.ec = 16'(ec);
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        bit prev_p;
        bit exp_p;
        tbl[0]  = mk(0,0,0,0,0,0, 0,8'h00,0,0,0,0);
        tbl[1]  = mk(1,0,0,3,0,0, 0,8'h00,0,0,1,0);
        tbl[2]  = mk(0,0,0,0,0,0, 0,8'h00,0,0,0,0);
        tbl[3]  = mk(1,1,0,3,4,0, 0,8'h00,0,0,0,0);
        tbl[4]  = mk(1,0,0,5,4,0, 1,8'h20,5,1,0,0);
        tbl[5]  = mk(1,0,1,2,9,0, 1,8'h20,5,1,0,0);
        tbl[6]  = mk(0,0,0,0,0,0, 1,8'h20,5,1,0,0);
        tbl[7]  = mk(0,0,0,0,0,0, 1,8'h20,5,1,0,0);
        tbl[8]  = mk(0,0,0,0,0,0, 0,8'h00,0,0,0,1);
        tbl[9]  = mk(0,0,0,0,0,0, 0,8'h00,0,0,0,1);
        tbl[10] = mk(1,0,1,7,2,0, 1,8'h80,7,1,0,0);
        tbl[11] = mk(0,0,0,0,0,0, 1,8'h80,7,1,0,0);
        tbl[12] = mk(0,0,0,0,0,0, 0,8'h00,7,1,0,1);
        tbl[13] = mk(0,0,0,0,0,0, 1,8'h80,7,1,0,1);
        tbl[14] = mk(0,0,0,0,0,0, 1,8'h80,7,1,0,1);
        tbl[15] = mk(0,0,0,0,0,0, 0,8'h00,7,1,0,2);
        tbl[16] = mk(0,1,0,0,0,0, 0,8'h00,0,0,0,2);
        tbl[17] = mk(0,0,0,0,0,0, 0,8'h00,0,0,0,2);

        do_reset();
        @(negedge clk);
        check("reset_state", longint'(outs()), 0);

        for (int i = 0; i < 18; i++) begin
            tick(tbl[i].o, tbl[i].c, tbl[i].md, tbl[i].w, tbl[i].p, tbl[i].g);
            check($sformatf("vec%0d", i), longint'(outs()),
                  longint'({tbl[i].ep, tbl[i].ech, tbl[i].ew, tbl[i].eb, tbl[i].ee, tbl[i].ec}));
            check_model("vec_model");
        end

        // Repeat run: plus=3 gap=2, close in cycle 20, stray open with wdis=2 in cycle 7.
        tick(1, 0, 1, 3'd1, 32'd3, 32'd2);
        for (int j = 1; j <= 22; j++) begin
            exp_p = (j <= 20) && (((j - 1) % 5) < 3);
            check($sformatf("rep_pulse%0d", j), longint'(pulse), longint'(exp_p));
            check("rep_busy", longint'(busy), longint'(j <= 20));
            if (j <= 20) check("rep_wdis", longint'(wdis_o), 1);
            if (j >= 21) check("rep_cnt", longint'(cnt), 4);
            check_model("rep_model");
            tick(j == 7, j == 20, 1'($urandom_range(0, 1)), (j == 7) ? 3'd2 : 3'($urandom_range(0, 7)),
                 32'($urandom_range(1, 9)), 32'($urandom_range(0, 9)));
        end

        // Asynchronous reset in the middle of a pulse, then an open on the first edge.
        tick(1, 0, 1, 3'd3, 32'd3, 32'd1);
        repeat (5) tick(0, 0, 0, 3'd0, 32'd0, 32'd0);
        check_model("pre_rst");
        check("pre_rst_cnt", longint'(cnt), 1);
        #2 rst = 1'b1;
        #1 check("async_rst", longint'(outs()), 0);
        @(negedge clk);
        rst = 1'b0;
        m_run = 0; m_err = 0; cyc = 0; m_close = BIG;
        tick(1, 0, 0, 3'd6, 32'd2, 32'd0);
        check("post_rst_open", longint'({pulse, chan, busy}), longint'({1'b1, 8'h40, 1'b1}));
        check_model("post_rst_model");
        tick(0, 0, 0, 3'd0, 32'd0, 32'd0);
        check_model("post_rst_model");
        tick(0, 0, 0, 3'd0, 32'd0, 32'd0);
        check("post_rst_done", longint'({pulse, busy, cnt}), longint'({1'b0, 1'b0, 16'd1}));

        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0,
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 32'($urandom_range(0, 5)), 32'($urandom_range(0, 4)));
            check_model("rand");
        end

        // plus=1 gap=0 alternates every cycle; counter preloaded near the top to reach saturation.
        tick(0, 1, 0, 3'd0, 32'd0, 32'd0);
        tick(0, 0, 0, 3'd0, 32'd0, 32'd0);
        tick(1, 0, 1, 3'd0, 32'd1, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check_model("gap0_model");
            tick(0, 0, 0, 3'd0, 32'd0, 32'd0);
        end
        force dut.cnt_q = 16'hFFFD;
        tick(0, 0, 0, 3'd0, 32'd0, 32'd0);
        release dut.cnt_q;
        prev_p = pulse;
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 0, 3'd0, 32'd0, 32'd0);
            check("gap0_alt", longint'(pulse), longint'(!prev_p));
            check("sat_no_wrap", longint'(cnt >= 16'hFFFD), 1);
            prev_p = pulse;
        end
        check("sat_cnt", longint'(cnt), 16'hFFFF);
        check("sat_busy", longint'(busy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
